// File: rtl/besdpb_ram.sv
// besdpb_ram: byte-enabled semi-dual-port RAM. One shared address feeds a
// lane-masked write port and a read-first registered read port.
module besdpb_ram #(
  parameter int unsigned ADDRESS_BITWIDTH = 16,
  parameter int unsigned DATA_BITWIDTH    = 32,
  parameter int unsigned COLUMN_BITWIDTH  = 8,
  parameter int unsigned COLUMN_COUNT     = 4,
  parameter              DATA_FILE        = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COLUMN_COUNT-1:0]     write_enable,
  input  logic [ADDRESS_BITWIDTH-1:0] address,
  input  logic [DATA_BITWIDTH-1:0]    data_in,
  output logic [DATA_BITWIDTH-1:0]    data_out
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_BITWIDTH;

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  logic [DATA_BITWIDTH-1:0] lane_mask_c;
  logic [DATA_BITWIDTH-1:0] data_out_d;
  logic [DATA_BITWIDTH-1:0] data_out_q;

  // Configuration-time contents: zeros.
  // The cache treats an all-zero tag word as invalid, so zero fill matters.
  initial begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      mem[k] = '0;
    end
  end

  // Expand per-lane strobes into a bit mask over the data word.
  for (genvar g = 0; g < COLUMN_COUNT; g++) begin : g_lane
    assign lane_mask_c[g*COLUMN_BITWIDTH +: COLUMN_BITWIDTH] = {COLUMN_BITWIDTH{write_enable[g]}};
  end

  // Array write: strobed lanes only, suppressed while in reset, no array reset.
  always_ff @(posedge clk) begin
    if (!rst && (|write_enable)) begin
      mem[address] <= (mem[address] & ~lane_mask_c) | (data_in & lane_mask_c);
    end
  end

  // Read-first: sample the word before this edge's write lands.
  always_comb begin
    data_out_d = mem[address];
  end

  // Read register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_besdpb_ram.sv
// Scoreboard bench for besdpb_ram: expected read data is queued when a cycle
// is driven and compared one edge later against data_out.
module tb_besdpb_ram;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [3:0]    write_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;

  int unsigned n_checks;
  int unsigned n_fails;

  logic [DW-1:0] model [int];
  logic [DW-1:0] exp_q [$];

  besdpb_ram #(
    .ADDRESS_BITWIDTH(AW),
    .DATA_BITWIDTH   (DW),
    .COLUMN_BITWIDTH (8),
    .COLUMN_COUNT    (4),
    .DATA_FILE       ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input int a);
    if (model.exists(a)) return model[a];
    return '0;
  endfunction

  // One clock cycle: drive at negedge, queue expectation, compare after posedge.
  task automatic step(input string tag, input logic [3:0] we, input int a, input logic [DW-1:0] din);
    logic [DW-1:0] old;
    logic [DW-1:0] m;
    logic [DW-1:0] got_exp;
    @(negedge clk);
    write_enable = we;
    address      = AW'(a);
    data_in      = din;
    old = model_rd(a);
    exp_q.push_back(rst ? DW'(0) : old);
    if (!rst && (we != 4'b0000)) begin
      for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{we[i]}};
      model[a] = (old & ~m) | (din & m);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: scoreboard empty, got 0x%08h expected an entry", tag, data_out);
    end else begin
      got_exp = exp_q.pop_front();
      check_eq(tag, data_out, got_exp);
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    rst          = 1'b1;
    write_enable = 4'b0000;
    address      = '0;
    data_in      = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_out", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step("zero_init", 4'b0000, 'h05, 32'h0);

    step("wr_full_rdfirst", 4'b1111, 'h10, 32'hDEADBEEF);
    step("rd_full", 4'b0000, 'h10, 32'h0);
    check_eq("rd_full_const", data_out, 32'hDEADBEEF);

    step("wr_mask_rdfirst", 4'b0101, 'h10, 32'h11223344);
    step("rd_mask", 4'b0000, 'h10, 32'h0);
    check_eq("rd_mask_const", data_out, 32'hDE22BE44);

    step("wr_20", 4'b1111, 'h20, 32'hAAAAAAAA);
    step("rd_20", 4'b0000, 'h20, 32'h0);
    step("rf_old", 4'b1111, 'h20, 32'h55555555);
    check_eq("rf_old_const", data_out, 32'hAAAAAAAA);
    step("rf_new", 4'b0000, 'h20, 32'h0);
    check_eq("rf_new_const", data_out, 32'h55555555);

    step("wr_01", 4'b1111, 'h01, 32'h1);
    step("wr_02", 4'b1111, 'h02, 32'h2);
    for (int i = 0; i < 6; i++) begin
      step("alt_addr", 4'b0000, (i % 2 == 0) ? 'h01 : 'h02, 32'h0);
      check_eq("alt_const", data_out, (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    step("wr_7f", 4'b1111, 'h7F, 32'hCAFEF00D);
    step("rd_7f", 4'b0000, 'h7F, 32'h0);
    // Mid-cycle reset must clear data_out with no clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_clr", data_out, 32'h0);
    step("rst_wr_7f", 4'b1111, 'h7F, 32'h12345678);
    step("rst_wr_05", 4'b0011, 'h05, 32'hFFFFFFFF);
    @(negedge clk);
    write_enable = 4'b0000;
    rst = 1'b0;
    step("post_rst_7f", 4'b0000, 'h7F, 32'h0);
    check_eq("post_rst_7f_const", data_out, 32'hCAFEF00D);
    step("post_rst_05", 4'b0000, 'h05, 32'h0);

    for (int i = 0; i < 60; i++) begin
      step("rand", 4'($urandom_range(0, 15)), int'($urandom_range(0, 7)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
